// File: rtl/sync_ram.sv
// Single-port synchronous RAM with a registered, write-first read port.
// Asynchronous active-low reset clears every word and the read register.
module sync_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array sits in the reset branch because reset must clear every
  // word at once; that rules out block-RAM inference and builds it from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      dout <= '0;
    end else if (we) begin
      // NOTE: non-blocking writes keep the array update and the read
      // register ordered as real flops, independent of statement order.
      mem[addr] <= din;
      dout      <= din;
    end else begin
      dout <= mem[addr];
    end
  end

endmodule

// File: tb/tb_sync_ram.sv
// Self-checking bench for sync_ram: constant vector table plus hand-written
// sequences for reset, hold-between-edges and mid-run reset.
module tb_sync_ram;

  logic       clk;
  logic       rst;
  logic       we;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q [$];

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs [14];

  sync_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [3:0] a, input logic [7:0] d,
                              input logic [7:0] e, input string n);
    vec_t v;
    v.we = w; v.addr = a; v.din = d; v.exp = e; v.name = n;
    return v;
  endfunction

  // Drive one cycle at the falling edge, push the expectation, then pop and
  // compare just after the rising edge that produces it.
  task automatic step(input logic w, input logic [3:0] a, input logic [7:0] d,
                      input logic [7:0] e, input string n);
    logic [7:0] x;
    @(negedge clk);
    we = w; addr = a; din = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty, got %h", n, dout);
    end else begin
      x = exp_q.pop_front();
      check(n, dout, x);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; addr = '0; din = '0;

    // Reset with garbage inputs: dout clears without a clock edge.
    @(negedge clk);
    rst = 1'b0; we = 1'bx; addr = 'x; din = 'x;
    #1;
    check("reset_immediate", dout, 8'h00);
    @(posedge clk);
    #1;
    check("reset_hold_edge", dout, 8'h00);
    @(negedge clk);
    rst = 1'b1; we = 1'b0; addr = '0; din = '0;

    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'(i), 8'h00, 8'h00, $sformatf("post_reset_rd%0d", i));
    end

    vecs[0]  = mk(1'b1, 4'd1,  8'hA0, 8'hA0, "wr1");
    vecs[1]  = mk(1'b1, 4'd2,  8'h40, 8'h40, "wr2");
    vecs[2]  = mk(1'b1, 4'd3,  8'hE0, 8'hE0, "wr3");
    vecs[3]  = mk(1'b1, 4'd4,  8'h80, 8'h80, "wr4");
    vecs[4]  = mk(1'b0, 4'd1,  8'hFF, 8'hA0, "rd1");
    vecs[5]  = mk(1'b0, 4'd2,  8'hFF, 8'h40, "rd2");
    vecs[6]  = mk(1'b0, 4'd3,  8'hFF, 8'hE0, "rd3");
    vecs[7]  = mk(1'b0, 4'd4,  8'hFF, 8'h80, "rd4");
    vecs[8]  = mk(1'b0, 4'd0,  8'h12, 8'h00, "unwritten0");
    vecs[9]  = mk(1'b0, 4'd15, 8'h34, 8'h00, "unwritten15");
    vecs[10] = mk(1'b1, 4'd5,  8'h3C, 8'h3C, "write_first5");
    vecs[11] = mk(1'b0, 4'd5,  8'h00, 8'h3C, "read_back5");
    vecs[12] = mk(1'b1, 4'd7,  8'h55, 8'h55, "wr7_55");
    vecs[13] = mk(1'b1, 4'd7,  8'hAA, 8'hAA, "wr7_aa");

    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].exp, vecs[i].name);
    end
    step(1'b0, 4'd7, 8'h00, 8'hAA, "overwrite_rd7");

    // Inputs changing between edges must not disturb dout.
    @(negedge clk);
    we = 1'b0; addr = 4'd1; din = 8'h99;
    #2;
    check("hold_between_edges", dout, 8'hAA);
    @(posedge clk);
    #1;
    check("hold_next_edge", dout, 8'hA0);

    step(1'b1, 4'd1, 8'h11, 8'h11, "refill1");
    step(1'b1, 4'd2, 8'h22, 8'h22, "refill2");
    step(1'b1, 4'd3, 8'h33, 8'h33, "refill3");
    step(1'b1, 4'd4, 8'h44, 8'h44, "refill4");

    // Mid-run reset with a write pending: the write must be lost.
    @(negedge clk);
    we = 1'b1; addr = 4'd6; din = 8'hFF; rst = 1'b0;
    #1;
    check("midrun_reset_immediate", dout, 8'h00);
    @(posedge clk);
    #1;
    check("midrun_reset_hold", dout, 8'h00);
    @(negedge clk);
    rst = 1'b1; we = 1'b0;

    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 4'(i), 8'h00, 8'h00, $sformatf("after_midrun_rd%0d", i));
    end
    step(1'b0, 4'd6, 8'h00, 8'h00, "lost_write_rd6");

    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
